// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-bank slave.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    RD_WAIT,
    READ,
    WRITE,
    IGNORE
  } state_e;

  localparam int unsigned RW_BIT     = 7;
  localparam int unsigned ADR_W      = 7;
  localparam int unsigned SYNC_DEPTH = 3;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with rise/fall detect.
module spi_pin_sync
  import spi_reg_pkg::*;
(
  input  logic clk,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic [SYNC_DEPTH-1:0] sync_d;

  always_comb sync_d = {sync_q[SYNC_DEPTH-2:0], din};

  // Deliberately not reset: the true pin level must be visible at reset release.
  always_ff @(posedge clk) sync_q <= sync_d;

  assign lvl  = sync_q[SYNC_DEPTH-1];
  assign rise = (sync_q[SYNC_DEPTH-1 -: 2] == 2'b01);
  assign fall = (sync_q[SYNC_DEPTH-1 -: 2] == 2'b10);

endmodule

// File: rtl/spi_reg_bank_slave.sv
// SPI mode-0 slave to a bank of N_REGS registers, all pins oversampled in clk.
// Define SPI_REG_AUTO_INC_EN for burst auto-increment; default is one word per frame.
module spi_reg_bank_slave
  import spi_reg_pkg::*;
#(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       N_REGS   = 4,
  parameter logic [ADR_W-1:0]  BASE_ADR = 7'h01,
  localparam int unsigned      IDX_W    = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sclk,
  input  logic                     mosi,
  input  logic                     cs_n,
  output logic                     miso,
  input  logic [N_REGS*DATA_W-1:0] rd_data,
  input  logic                     rd_wait,
  output logic                     rd_strobe,
  output logic [DATA_W-1:0]        wr_data,
  output logic [IDX_W-1:0]         wr_idx,
  output logic                     wr_valid,
  output logic                     busy
);

  localparam int unsigned      CNT_W     = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_W - 1);
  localparam logic [ADR_W:0]   N_REGS_EXT = (ADR_W + 1)'(N_REGS);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic unused_sync;

  spi_pin_sync u_sclk_sync (.clk(clk), .din(sclk), .lvl(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_pin_sync u_cs_sync   (.clk(clk), .din(cs_n), .lvl(cs_lvl),   .rise(cs_rise),   .fall(cs_fall));

  assign unused_sync = sclk_lvl & cs_fall;

  logic [SYNC_DEPTH-1:0] mosi_sync_q;
  logic                  mosi_s;
  assign mosi_s = mosi_sync_q[SYNC_DEPTH-1];

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RW_BIT-1:0]   cmd_q, cmd_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                armed_q, armed_d;
  logic                rd_strobe_q, rd_strobe_d;
  logic                wr_valid_q, wr_valid_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;

  logic [RW_BIT:0]     cmd_full;
  logic [ADR_W:0]      adr_off;
  logic                in_win;

  always_ff @(posedge clk) begin
    mosi_sync_q <= {mosi_sync_q[SYNC_DEPTH-2:0], mosi};
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      shreg_q     <= '0;
      idx_q       <= '0;
      armed_q     <= 1'b0;
      rd_strobe_q <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_data_q   <= '0;
      wr_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      armed_q     <= armed_d;
      rd_strobe_q <= rd_strobe_d;
      wr_valid_q  <= wr_valid_d;
      wr_data_q   <= wr_data_d;
      wr_idx_q    <= wr_idx_d;
    end
  end

  // Addresses below BASE_ADR wrap to a large offset and fall outside the window.
  always_comb begin
    cmd_full = {cmd_q, mosi_s};
    adr_off  = {1'b0, cmd_full[ADR_W-1:0]} - {1'b0, BASE_ADR};
    in_win   = (adr_off < N_REGS_EXT);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    armed_d     = armed_q | cs_lvl;
    rd_strobe_d = 1'b0;
    wr_valid_d  = 1'b0;
    wr_data_d   = wr_data_q;
    wr_idx_d    = wr_idx_q;

    if (cs_rise) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        // Not armed means cs_n was already low at reset release: sit out that frame.
        IDLE: begin
          cnt_d = '0;
          if (!cs_lvl) state_d = armed_q ? ADDR : IGNORE;
        end
        ADDR: if (sclk_rise) begin
          cmd_d = cmd_full[RW_BIT-1:0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CMD_LAST) begin
            cnt_d = '0;
            idx_d = adr_off[IDX_W-1:0];
            if (!in_win)               state_d = IGNORE;
            else if (cmd_full[RW_BIT]) state_d = WRITE;
            else                       state_d = RD_WAIT;
          end
        end
        RD_WAIT: if (!rd_wait) begin
          shreg_d     = rd_data[idx_q*DATA_W +: DATA_W];
          rd_strobe_d = 1'b1;
          wr_idx_d    = idx_q;
          state_d     = READ;
        end
        // The fall that trails the last command/word bit must not shift the fresh snapshot.
        READ: begin
          if (sclk_rise) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == WORD_LAST) begin
              cnt_d = '0;
`ifdef SPI_REG_AUTO_INC_EN
              idx_d   = (idx_q == IDX_W'(N_REGS - 1)) ? '0 : idx_q + 1'b1;
              state_d = RD_WAIT;
`else
              state_d = IGNORE;
`endif
            end
          end else if (sclk_fall && (cnt_q != '0)) begin
            shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
          end
        end
        WRITE: if (sclk_rise) begin
          shreg_d = {shreg_q[DATA_W-2:0], mosi_s};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == WORD_LAST) begin
            cnt_d      = '0;
            wr_data_d  = shreg_d;
            wr_idx_d   = idx_q;
            wr_valid_d = 1'b1;
`ifdef SPI_REG_AUTO_INC_EN
            idx_d   = (idx_q == IDX_W'(N_REGS - 1)) ? '0 : idx_q + 1'b1;
            state_d = WRITE;
`else
            state_d = IGNORE;
`endif
          end
        end
        IGNORE: state_d = IGNORE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == RD_WAIT) || (state_q == READ) || (state_q == WRITE);
    miso = (state_q == READ) ? shreg_q[DATA_W-1] : 1'b1;
  end

  assign rd_strobe = rd_strobe_q;
  assign wr_valid  = wr_valid_q;
  assign wr_data   = wr_data_q;
  assign wr_idx    = wr_idx_q;

endmodule

// File: tb/tb_spi_reg_bank_slave.sv
// Randomised self-checking bench for spi_reg_bank_slave against a frame-level model.
module tb_spi_reg_bank_slave;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned N_REGS   = 4;
  localparam logic [6:0]  BASE_ADR = 7'h01;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned HALF     = 8;
`ifdef SPI_REG_AUTO_INC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     sclk = 1'b0;
  logic                     mosi = 1'b0;
  logic                     cs_n = 1'b1;
  logic                     miso;
  logic [N_REGS*DATA_W-1:0] rd_data = '0;
  logic                     rd_wait = 1'b0;
  logic                     rd_strobe;
  logic [DATA_W-1:0]        wr_data;
  logic [IDX_W-1:0]         wr_idx;
  logic                     wr_valid;
  logic                     busy;

  spi_reg_bank_slave #(.DATA_W(DATA_W), .N_REGS(N_REGS), .BASE_ADR(BASE_ADR)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso(miso),
    .rd_data(rd_data), .rd_wait(rd_wait), .rd_strobe(rd_strobe),
    .wr_data(wr_data), .wr_idx(wr_idx), .wr_valid(wr_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Event log from the DUT outputs; frames look at what was added since they began.
  logic [IDX_W-1:0]  wr_idx_log[$];
  logic [DATA_W-1:0] wr_data_log[$];
  logic [IDX_W-1:0]  strobe_idx_log[$];
  int unsigned busy_cyc = 0, miso_low_cyc = 0, strobe_in_wait = 0;

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (wr_valid) begin
        wr_idx_log.push_back(wr_idx);
        wr_data_log.push_back(wr_data);
      end
      if (rd_strobe) begin
        strobe_idx_log.push_back(wr_idx);
        if (rd_wait) strobe_in_wait++;
      end
      if (busy) busy_cyc++;
      if (!miso) miso_low_cyc++;
    end
  end

  logic [DATA_W-1:0] regs[N_REGS];
  logic [DATA_W-1:0] tx_words[4];

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_regs();
    for (int i = 0; i < int'(N_REGS); i++) rd_data[i*DATA_W +: DATA_W] = regs[i];
  endtask

  task automatic spi_bits(input logic [31:0] tx, input int nbits, output logic [31:0] rx);
    rx = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = tx[i];
      tick(HALF);
      sclk = 1'b1;
      rx = {rx[30:0], miso};
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  int unsigned b_wr, b_st, b_busy, b_miso, b_wait;

  task automatic mark();
    b_wr   = wr_idx_log.size();
    b_st   = strobe_idx_log.size();
    b_busy = busy_cyc;
    b_miso = miso_low_cyc;
    b_wait = strobe_in_wait;
  endtask

  // One frame: command byte, optional rd_wait hold (with a source update), nw words.
  task automatic run_frame(input logic rw, input logic [6:0] adr, input int unsigned nw,
                           input int unsigned wait_clk, input logic [DATA_W-1:0] chg_val);
    logic [31:0]       rx;
    logic [DATA_W-1:0] exp_w;
    int                a, idx0;
    bit                win;
    int unsigned       n_exp, got;
    a     = int'(adr);
    win   = (a >= int'(BASE_ADR)) && (a < int'(BASE_ADR) + int'(N_REGS));
    idx0  = a - int'(BASE_ADR);
    n_exp = !win ? 0 : (AUTO ? nw : 1);
    mark();
    rd_wait = (wait_clk != 0);
    cs_n = 1'b0;
    tick(4);
    spi_bits(32'({rw, adr}), 8, rx);
    if (wait_clk != 0) begin
      tick(wait_clk);
      if (win && !rw) begin
        regs[idx0] = chg_val;
        drive_regs();
      end
      tick(1);
      rd_wait = 1'b0;
    end
    tick(6);
    for (int w = 0; w < int'(nw); w++) begin
      spi_bits(32'(tx_words[w]), DATA_W, rx);
      if (!rw) begin
        exp_w = (win && (w == 0 || AUTO)) ? regs[(idx0 + w) % int'(N_REGS)] : '1;
        check_eq($sformatf("rd_word[%0d]@%0h", w, adr), rx, 32'(exp_w));
      end
      tick(6);
    end
    cs_n = 1'b1;
    tick(6);
    got = wr_idx_log.size() - b_wr;
    check_eq($sformatf("wr_count@%0h", adr), got, rw ? n_exp : 0);
    for (int k = 0; k < int'(got) && rw && k < int'(n_exp); k++) begin
      check_eq($sformatf("wr_idx[%0d]", k), 32'(wr_idx_log[b_wr + k]), (idx0 + k) % int'(N_REGS));
      check_eq($sformatf("wr_data[%0d]", k), 32'(wr_data_log[b_wr + k]), 32'(tx_words[k]));
    end
    got = strobe_idx_log.size() - b_st;
    check_eq($sformatf("strobe_count@%0h", adr), got, rw ? 0 : n_exp);
    for (int k = 0; k < int'(got) && !rw && k < int'(n_exp); k++)
      check_eq($sformatf("strobe_idx[%0d]", k), 32'(strobe_idx_log[b_st + k]), (idx0 + k) % int'(N_REGS));
    check_eq("strobe_during_wait", strobe_in_wait - b_wait, 0);
    check_eq($sformatf("busy_seen@%0h", adr), 32'(busy_cyc != b_busy), 32'(win));
    if (rw || !win) check_eq($sformatf("miso_quiet@%0h", adr), miso_low_cyc - b_miso, 0);
    check_eq("busy_after", 32'(busy), 0);
    check_eq("miso_after", 32'(miso), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_miso"}, 32'(miso), 1);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_rd_strobe"}, 32'(rd_strobe), 0);
    check_eq({tag, "_wr_valid"}, 32'(wr_valid), 0);
    check_eq({tag, "_wr_data"}, 32'(wr_data), 0);
    check_eq({tag, "_wr_idx"}, 32'(wr_idx), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rx;
    for (int i = 0; i < int'(N_REGS); i++) regs[i] = DATA_W'(16'h1000 * (i + 1));
    drive_regs();
    tick(4);
    rst = 1'b0;
    tick(2);
    check_reset_outputs("reset");

    tx_words[0] = 16'hBEEF;
    run_frame(1'b1, 7'h01, 1, 0, '0);
    regs[2] = 16'h1234;
    drive_regs();
    run_frame(1'b0, 7'h03, 1, 0, '0);
    run_frame(1'b0, 7'h02, 1, 20, 16'h5A5A);
    run_frame(1'b0, 7'h10, 1, 0, '0);
    run_frame(1'b0, 7'h00, 1, 0, '0);
    run_frame(1'b1, 7'h00, 1, 0, '0);
    run_frame(1'b1, 7'h05, 1, 0, '0);
    tx_words[0] = 16'h1111; tx_words[1] = 16'h2222; tx_words[2] = 16'h3333;
    run_frame(1'b1, 7'h83 & 7'h7F, 3, 0, '0);
    run_frame(1'b0, 7'h04, 2, 0, '0);

    // cs_n released after 9 bits of a write: partial word dropped.
    mark();
    cs_n = 1'b0;
    tick(4);
    spi_bits(32'h82, 8, rx);
    tick(6);
    spi_bits(32'h1, 1, rx);
    tick(6);
    cs_n = 1'b1;
    tick(6);
    check_eq("partial_wr_count", wr_idx_log.size() - b_wr, 0);
    check_eq("partial_busy_after", 32'(busy), 0);

    // rst mid-read, then the rest of the frame (plus a write command) must be ignored.
    cs_n = 1'b0;
    tick(4);
    spi_bits(32'h01, 8, rx);
    tick(6);
    spi_bits(32'h0, 5, rx);
    rst = 1'b1;
    tick(2);
    check_reset_outputs("midrst");
    rst = 1'b0;
    tick(2);
    mark();
    spi_bits(32'h7FF, 11, rx);
    tick(6);
    spi_bits(32'h81, 8, rx);
    tick(6);
    spi_bits(32'hCAFE, DATA_W, rx);
    tick(6);
    cs_n = 1'b1;
    tick(6);
    check_eq("postrst_wr_count", wr_idx_log.size() - b_wr, 0);
    check_eq("postrst_strobe_count", strobe_idx_log.size() - b_st, 0);
    check_eq("postrst_busy_cycles", busy_cyc - b_busy, 0);
    check_eq("postrst_miso_low", miso_low_cyc - b_miso, 0);
    tx_words[0] = 16'h600D;
    run_frame(1'b1, 7'h02, 1, 0, '0);

    for (int f = 0; f < 16; f++) begin
      logic [6:0] adr;
      logic       rw;
      int unsigned nw, wc;
      for (int i = 0; i < int'(N_REGS); i++) regs[i] = DATA_W'($urandom);
      drive_regs();
      for (int w = 0; w < 4; w++) tx_words[w] = DATA_W'($urandom);
      rw  = 1'($urandom);
      adr = ($urandom_range(0, 9) < 7) ? 7'(int'(BASE_ADR) + int'($urandom_range(0, N_REGS - 1)))
                                       : 7'($urandom_range(0, 127));
      nw  = $urandom_range(1, 3);
      wc  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : 0;
      run_frame(rw, adr, nw, wc, DATA_W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
